reduction_feeder: RTL



---
 rtl/reduction_feeder_if.sv | 37 +++
 rtl/reduction_feeder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reduction_feeder_if.sv
// -----------------------------------------------------------------------------
// reduction_feeder_if
//   Upstream result-word stream into the reduction feeder: valid/ready
//   handshake with a last-word marker.
//
//   Signals
//     in_valid  producer -> feeder  word on in_data is valid
//     in_data   producer -> feeder  result word (DWIDTH bits)
//     in_last   producer -> feeder  word is the final one of a block
//     in_ready  feeder -> producer  feeder accepts a word this cycle
//
//   Modports
//     master  the producer side (drives valid/data/last)
//     slave   the feeder side (drives ready)
// -----------------------------------------------------------------------------
interface reduction_feeder_if #(
  parameter int DWIDTH = 20
);
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface : reduction_feeder_if

// File: rtl/reduction_feeder.sv
// -----------------------------------------------------------------------------
// reduction_feeder
//   Collects one block of result words from an upstream valid/ready stream,
//   writes them to consecutive addresses of the reduction input BRAM starting
//   at cfg_base_addr, then pulses red_start for START_HOLD cycles with the
//   address range and reduction type, and waits for red_done before taking
//   the next block.
//
//   Parameters
//     DWIDTH      BRAM word width
//     AWIDTH      BRAM address width
//     START_HOLD  cycles red_start is held high (1..15)
//
//   Ports
//     clk, resetn             clock, asynchronous active-low reset
//     up (slave)              in_valid/in_data/in_last in, in_ready out
//     cfg_base_addr, cfg_type block base address and reduction type,
//                             sampled when a block starts
//     bram_we/addr/wdata      registered BRAM write port
//     red_start               start pulse to the reduction layer
//     red_start_addr/end_addr inclusive address range to reduce
//     red_type                reduction type to the reduction layer
//     red_done                reduction layer finished (honoured in WAIT only)
//     busy                    high in any state but IDLE
//     wrap_err                sticky: the write pointer wrapped inside a block
// -----------------------------------------------------------------------------
module reduction_feeder #(
  parameter int DWIDTH     = 20,
  parameter int AWIDTH     = 11,
  parameter int START_HOLD = 4
) (
  input  logic              clk,
  input  logic              resetn,

  reduction_feeder_if.slave up,

  input  logic [AWIDTH-1:0] cfg_base_addr,
  input  logic [1:0]        cfg_type,

  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_wdata,

  output logic              red_start,
  output logic [AWIDTH-1:0] red_start_addr,
  output logic [AWIDTH-1:0] red_end_addr,
  output logic [1:0]        red_type,
  input  logic              red_done,

  output logic              busy,
  output logic              wrap_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_KICK = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [AWIDTH-1:0] PTR_MAX = '1;
  localparam logic [3:0]        HOLD    = 4'(START_HOLD);

  state_t            state;
  logic [AWIDTH-1:0] wr_ptr;
  logic [3:0]        kick_cnt;
  logic              in_ready;
  logic              accept;

  assign up.in_ready = in_ready;

  // in_ready is only ever high in FILL; qualifying with the state as well
  // keeps a stray valid in any other state from being taken as a beat.
  assign accept = (state == S_FILL) && in_ready && up.in_valid;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would make the
  // result depend on statement order and break the one-cycle write latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      kick_cnt       <= '0;
      in_ready       <= 1'b0;
      bram_we        <= 1'b0;
      bram_addr      <= '0;
      bram_wdata     <= '0;
      red_start      <= 1'b0;
      red_start_addr <= '0;
      red_end_addr   <= '0;
      red_type       <= '0;
      busy           <= 1'b0;
      wrap_err       <= 1'b0;
    end else begin
      // NOTE: bram_we defaults low every cycle so it is a one-cycle strobe
      // that only follows an accepted beat; address and data simply hold.
      bram_we <= 1'b0;

      if (accept) begin
        bram_we    <= 1'b1;
        bram_addr  <= wr_ptr;
        bram_wdata <= up.in_data;
        wr_ptr     <= wr_ptr + 1'b1;   // natural modulo-2^AWIDTH wrap
      end

      case (state)
        S_IDLE: begin
          // The first valid only opens the block; it is taken next cycle.
          if (up.in_valid) begin
            state          <= S_FILL;
            in_ready       <= 1'b1;
            busy           <= 1'b1;
            wr_ptr         <= cfg_base_addr;
            red_start_addr <= cfg_base_addr;
            red_type       <= cfg_type;
            wrap_err       <= 1'b0;
          end
        end

        S_FILL: begin
          if (accept) begin
            if (up.in_last) begin
              red_end_addr <= wr_ptr;
              in_ready     <= 1'b0;
              kick_cnt     <= '0;
              state        <= S_KICK;
            end else if (wr_ptr == PTR_MAX) begin
              // A block running past the top of the BRAM is written anyway;
              // the flag tells the consumer the range is not monotonic.
              wrap_err <= 1'b1;
            end
          end
        end

        S_KICK: begin
          // The first KICK cycle carries the final BRAM write, so red_start
          // rises one cycle later and stays up for exactly HOLD cycles.
          // red_done is deliberately not looked at here.
          if (kick_cnt == HOLD) begin
            red_start <= 1'b0;
            state     <= S_WAIT;
          end else begin
            red_start <= 1'b1;
            kick_cnt  <= kick_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (red_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : reduction_feeder
